// File: rtl/spi_master_engine.sv
// SPI mode-0 master engine: one DATA_W-bit MSB-first frame per go_transfer edge,
// returning the received word with a stretched data_pack_ready level.
module spi_master_engine #(
  parameter int DATA_W     = 32,
  parameter int CLK_DIV    = 4,
  parameter int READY_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go_transfer,
  input  logic [DATA_W-1:0] data_write_to_spi,
  output logic [DATA_W-1:0] data_read_from_spi,
  output logic              data_pack_ready,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = $clog2(READY_HOLD + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(READY_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t              state;
  logic [2:0]          go_sync;
  logic                start;
  logic                div_end;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rx_sr;

  // Two flops to synchronise, the third only serves the rising-edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) go_sync <= '0;
    else          go_sync <= {go_sync[1:0], go_transfer};
  end

  assign start   = go_sync[1] & ~go_sync[2];
  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      div_cnt            <= '0;
      bit_cnt            <= '0;
      hold_cnt           <= '0;
      tx_sr              <= '0;
      rx_sr              <= '0;
      data_read_from_spi <= '0;
      data_pack_ready    <= 1'b0;
      busy               <= 1'b0;
      spi_sclk           <= 1'b0;
      spi_cs_n           <= 1'b1;
      spi_mosi           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tx_sr    <= data_write_to_spi;
            spi_mosi <= data_write_to_spi[DATA_W-1];
            rx_sr    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          // The first rising edge starts the SHIFT phase and samples bit MSB.
          if (div_end) begin
            div_cnt  <= '0;
            spi_sclk <= 1'b1;
            rx_sr    <= {rx_sr[DATA_W-2:0], spi_miso};
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (spi_sclk) begin
              spi_sclk <= 1'b0;
              tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
              spi_mosi <= tx_sr[DATA_W-2];
              bit_cnt  <= bit_cnt + 1'b1;
            end else if (bit_cnt == BIT_LAST) begin
              // Low half of the last period is complete; sclk stays low.
              state <= HOLD;
            end else begin
              spi_sclk <= 1'b1;
              rx_sr    <= {rx_sr[DATA_W-2:0], spi_miso};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_end) begin
            div_cnt            <= '0;
            hold_cnt           <= '0;
            spi_cs_n           <= 1'b1;
            data_read_from_spi <= rx_sr;
            data_pack_ready    <= 1'b1;
            state              <= DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          if (hold_cnt == HOLD_LAST) begin
            data_pack_ready <= 1'b0;
            busy            <= 1'b0;
            state           <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Scenario bench for spi_master_engine: expected words go into a scoreboard queue at
// stimulus time and are popped when data_pack_ready rises.
module tb_spi_master_engine;
  localparam int DATA_W     = 32;
  localparam int CLK_DIV    = 4;
  localparam int READY_HOLD = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              go_transfer = 1'b0;
  logic [DATA_W-1:0] data_write_to_spi = '0;
  logic [DATA_W-1:0] data_read_from_spi;
  logic              data_pack_ready;
  logic              busy;
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              loop_en = 1'b1;
  logic              miso_val = 1'b0;

  assign spi_miso = loop_en ? spi_mosi : miso_val;

  spi_master_engine #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .READY_HOLD(READY_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .go_transfer(go_transfer),
    .data_write_to_spi(data_write_to_spi), .data_read_from_spi(data_read_from_spi),
    .data_pack_ready(data_pack_ready), .busy(busy), .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_val;

  int cyc = 0, sclk_rises = 0, period_bad = 0, mosi_bad = 0, mosi_ones = 0;
  int frames_done = 0, last_cs_len = 0, last_ready_len = 0, cs_run = 0, ready_run = 0;
  int last_rise_cyc = 0;
  bit have_rise = 0;
  logic sclk_prev = 0, cs_prev = 1, ready_prev = 0, mosi_prev = 0;
  logic [DATA_W-1:0] mosi_cap = '0;

  // Bus monitor and scoreboard consumer, sampled on the inactive edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      sclk_prev = 0; cs_prev = 1; ready_prev = 0; mosi_prev = 0;
      cs_run = 0; ready_run = 0; have_rise = 0;
    end else begin
      if (spi_sclk && !sclk_prev) begin
        sclk_rises++;
        mosi_cap = {mosi_cap[DATA_W-2:0], spi_mosi};
        if (have_rise && (cyc - last_rise_cyc) != 2 * CLK_DIV) period_bad++;
        have_rise = 1;
        last_rise_cyc = cyc;
      end
      if (spi_mosi !== mosi_prev && spi_sclk) mosi_bad++;
      if (!spi_cs_n && spi_mosi) mosi_ones++;
      if (!spi_cs_n) cs_run++;
      else begin
        if (!cs_prev) last_cs_len = cs_run;
        cs_run = 0;
        have_rise = 0;
      end
      if (data_pack_ready) begin
        if (!ready_prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: rx=%h but no frame was expected", data_read_from_spi);
          end else begin
            exp_val = exp_q.pop_front();
            if (data_read_from_spi !== exp_val) begin
              errors++;
              $display("FAIL rx_word: got %h expected %h", data_read_from_spi, exp_val);
            end
            $display("frame %0d: rx=%h expected=%h", frames_done, data_read_from_spi, exp_val);
          end
          frames_done++;
        end
        ready_run++;
      end else begin
        if (ready_prev) last_ready_len = ready_run;
        ready_run = 0;
      end
      sclk_prev = spi_sclk; cs_prev = spi_cs_n; ready_prev = data_pack_ready; mosi_prev = spi_mosi;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic go_pulse(input logic [DATA_W-1:0] tx, input int len);
    @(posedge clk); #1;
    data_write_to_spi = tx;
    go_transfer = 1'b1;
    repeat (len) @(posedge clk);
    #1 go_transfer = 1'b0;
  endtask

  task automatic wait_done(input int f_before, input string name);
    int n = 0;
    while (frames_done <= f_before && n < 2000) begin @(negedge clk); n++; end
    n = 0;
    while ((busy || data_pack_ready) && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    checks++;
    if (frames_done <= f_before || busy) begin
      errors++;
      $display("FAIL %s_timeout: frames=%0d busy=%b, required frames>%0d busy=0", name, frames_done, busy, f_before);
    end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({spi_cs_n, spi_sclk, spi_mosi, data_pack_ready, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: cs_n/sclk/mosi/ready/busy=%b required 10000",
               {spi_cs_n, spi_sclk, spi_mosi, data_pack_ready, busy});
    end
    checks++;
    if (data_read_from_spi !== '0) begin
      errors++;
      $display("FAIL reset_rx: got %h required 0", data_read_from_spi);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    $display("reset: cs_n=%b sclk=%b busy=%b rx=%h", spi_cs_n, spi_sclk, busy, data_read_from_spi);
  endtask

  task automatic test_loopback;
    int r0, f0, p0;
    logic [DATA_W-1:0] tx = 32'hA5C3_0F11;
    loop_en = 1'b1;
    exp_q.push_back(tx);
    r0 = sclk_rises; f0 = frames_done; p0 = period_bad;
    @(posedge clk); #1;
    data_write_to_spi = tx;
    go_transfer = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (spi_cs_n !== 1'b1) begin
      errors++; $display("FAIL start_early: cs_n=%b required 1 two clocks after go", spi_cs_n);
    end
    @(posedge clk); #1;
    checks++;
    if (spi_cs_n !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL start_latency: cs_n=%b busy=%b required 0/1 three clocks after go", spi_cs_n, busy);
    end
    @(posedge clk); #1 go_transfer = 1'b0;
    wait_done(f0, "loopback");
    checks++;
    if (sclk_rises - r0 != DATA_W) begin
      errors++; $display("FAIL loop_rises: got %0d required %0d", sclk_rises - r0, DATA_W);
    end
    checks++;
    if (last_cs_len != (2 * DATA_W + 2) * CLK_DIV) begin
      errors++; $display("FAIL cs_len: got %0d required %0d", last_cs_len, (2 * DATA_W + 2) * CLK_DIV);
    end
    checks++;
    if (last_ready_len != READY_HOLD) begin
      errors++; $display("FAIL ready_len: got %0d required %0d", last_ready_len, READY_HOLD);
    end
    checks++;
    if (period_bad != p0) begin
      errors++; $display("FAIL sclk_period: %0d periods not %0d clk", period_bad - p0, 2 * CLK_DIV);
    end
    checks++;
    if (mosi_cap !== tx) begin
      errors++; $display("FAIL loop_mosi: got %h required %h", mosi_cap, tx);
    end
    $display("loopback: rx=%h rises=%0d cs_len=%0d ready_len=%0d", data_read_from_spi,
             sclk_rises - r0, last_cs_len, last_ready_len);
  endtask

  task automatic test_miso_const;
    int f0, m0;
    loop_en = 1'b0;
    miso_val = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    f0 = frames_done; m0 = mosi_ones;
    go_pulse(32'h0, 4);
    wait_done(f0, "miso_one");
    checks++;
    if (mosi_ones != m0) begin
      errors++; $display("FAIL mosi_zero: mosi high for %0d cycles required 0", mosi_ones - m0);
    end
    $display("miso=1: rx=%h", data_read_from_spi);
    miso_val = 1'b0;
    exp_q.push_back(32'h0);
    f0 = frames_done;
    go_pulse(32'h0, 4);
    wait_done(f0, "miso_zero");
    $display("miso=0: rx=%h", data_read_from_spi);
    loop_en = 1'b1;
  endtask

  task automatic test_go_long;
    int r0, f0, n, busy_drop;
    logic [DATA_W-1:0] tx = 32'h5A5A_3C3C;
    loop_en = 1'b1;
    exp_q.push_back(tx);
    r0 = sclk_rises; f0 = frames_done;
    go_pulse(tx, 7);
    n = 0;
    while (sclk_rises - r0 < 6 && n < 500) begin @(negedge clk); n++; end
    go_pulse(32'hFFFF_0000, 4);
    n = 0; busy_drop = 0;
    while (frames_done == f0 && n < 2000) begin
      @(negedge clk);
      if (!busy) busy_drop++;
      n++;
    end
    checks++;
    if (busy_drop != 0) begin
      errors++; $display("FAIL busy_hold: busy low for %0d cycles mid-frame required 0", busy_drop);
    end
    wait_done(f0, "go_long");
    checks++;
    if (sclk_rises - r0 != DATA_W) begin
      errors++; $display("FAIL go_long_rises: got %0d required %0d", sclk_rises - r0, DATA_W);
    end
    repeat (300) @(posedge clk); #1;
    checks++;
    if (frames_done != f0 + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_frame: frames=%0d busy=%b required %0d/0", frames_done - f0, busy, 1);
    end
    $display("go_long: frames=%0d rx=%h", frames_done - f0, data_read_from_spi);
  endtask

  task automatic test_mid_reset;
    int r0, f0, n;
    loop_en = 1'b1;
    r0 = sclk_rises;
    go_pulse(32'hDEAD_BEEF, 4);
    n = 0;
    while (sclk_rises - r0 < 10 && n < 500) begin @(negedge clk); n++; end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({spi_cs_n, spi_sclk, busy, data_pack_ready} !== 4'b1000 || data_read_from_spi !== '0) begin
      errors++;
      $display("FAIL mid_reset: cs_n/sclk/busy/ready=%b rx=%h required 1000 rx=0",
               {spi_cs_n, spi_sclk, busy, data_pack_ready}, data_read_from_spi);
    end
    repeat (3) @(posedge clk); #1 reset_n = 1'b1;
    f0 = frames_done;
    repeat (400) @(posedge clk); #1;
    checks++;
    if (frames_done != f0 || busy !== 1'b0 || spi_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: frames=%0d busy=%b cs_n=%b required 0/0/1", frames_done - f0, busy, spi_cs_n);
    end
    $display("mid_reset: rises_before=%0d frames_after=%0d", sclk_rises - r0, frames_done - f0);
  endtask

  task automatic test_back_to_back;
    int f0;
    loop_en = 1'b1;
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h8765_4321);
    f0 = frames_done;
    go_pulse(32'h1234_5678, 4);
    wait_done(f0, "b2b_first");
    $display("b2b first: rx=%h", data_read_from_spi);
    go_pulse(32'h8765_4321, 4);
    wait_done(f0 + 1, "b2b_second");
    checks++;
    if (frames_done != f0 + 2) begin
      errors++; $display("FAIL b2b_frames: got %0d required 2", frames_done - f0);
    end
    $display("b2b second: rx=%h", data_read_from_spi);
  endtask

  task automatic test_mosi_model;
    int f0, m0;
    logic [DATA_W-1:0] tx = 32'h8000_0001;
    loop_en = 1'b1;
    exp_q.push_back(tx);
    f0 = frames_done; m0 = mosi_bad;
    @(posedge clk); #1;
    data_write_to_spi = tx;
    go_transfer = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (spi_mosi !== 1'b1 || spi_sclk !== 1'b0 || spi_cs_n !== 1'b0) begin
      errors++;
      $display("FAIL setup_mosi: mosi/sclk/cs_n=%b required 100", {spi_mosi, spi_sclk, spi_cs_n});
    end
    go_transfer = 1'b0;
    wait_done(f0, "mosi_model");
    checks++;
    if (mosi_cap !== tx) begin
      errors++; $display("FAIL mosi_order: got %h required %h", mosi_cap, tx);
    end
    checks++;
    if (mosi_bad != m0) begin
      errors++; $display("FAIL mosi_timing: %0d changes while sclk high required 0", mosi_bad - m0);
    end
    $display("mosi_model: captured=%h", mosi_cap);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_mid_reset();
    test_miso_const();
    test_go_long();
    test_back_to_back();
    test_mosi_model();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d frames never completed, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
